// File: rtl/tl_tx_arb_if.sv
// Framer-side TX port of the TLP scheduler: one header beat, then zero or more payload beats.
// master = scheduler (drives header/payload), slave = framer (drives the readies).
interface tl_tx_arb_if #(
  parameter int unsigned HDR_W  = 128,
  parameter int unsigned DATA_W = 256
) ();
  logic [HDR_W-1:0]  tx_hdr_o;
  logic              tx_hdr_valid_o;
  logic              tx_hdr_ready_i;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_data_valid_o;
  logic              tx_data_last_o;
  logic              tx_data_ready_i;
  logic [1:0]        tx_src_o;

  modport master (
    output tx_hdr_o, tx_hdr_valid_o, tx_data_o, tx_data_valid_o, tx_data_last_o, tx_src_o,
    input  tx_hdr_ready_i, tx_data_ready_i
  );

  modport slave (
    input  tx_hdr_o, tx_hdr_valid_o, tx_data_o, tx_data_valid_o, tx_data_last_o, tx_src_o,
    output tx_hdr_ready_i, tx_data_ready_i
  );
endinterface

// File: rtl/tl_tx_arb.sv
// Transmit-side TLP scheduler: credit-gated round-robin over posted, non-posted and completion
// sources, holding the grant for a whole TLP and consuming credits once at grant.
module tl_tx_arb #(
  parameter int unsigned HDR_W  = 128,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned CRED_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3*HDR_W-1:0]  src_hdr_i,
  input  logic [2:0]          src_hdr_valid_i,
  output logic [2:0]          src_hdr_ready_o,
  input  logic [2:0]          src_has_data_i,
  input  logic [3*LEN_W-1:0]  src_len_i,
  input  logic [3*DATA_W-1:0] src_data_i,
  input  logic [2:0]          src_data_valid_i,
  output logic [2:0]          src_data_ready_o,
  input  logic [2:0]          hdr_cred_ok_i,
  input  logic [3*CRED_W-1:0] data_cred_i,
  output logic [2:0]          hdr_consume_o,
  output logic [2:0]          data_consume_v_o,
  output logic [CRED_W-1:0]   data_consume_o,
  tl_tx_arb_if.master         tx
);

  localparam int unsigned DPB = DATA_W / 32;
  localparam int unsigned LW  = LEN_W + 1;

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e        state_q, state_d;
  logic [1:0]    g_q, g_d;
  logic [1:0]    rr_q, rr_d;
  logic [LW-1:0] cnt_q, cnt_d;

  logic [LW-1:0] len_full [3];
  logic [LW-1:0] need     [3];
  logic [LW-1:0] beats    [3];
  logic [2:0]    elig;
  logic          any_elig;
  logic [1:0]    pick;
  logic [1:0]    g_next;

  // Length field 0 encodes the maximum 1024 DW payload.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      len_full[i] = (src_len_i[i*LEN_W +: LEN_W] == '0) ? LW'(1 << LEN_W)
                                                        : LW'(src_len_i[i*LEN_W +: LEN_W]);
      need[i]     = (len_full[i] + LW'(3)) >> 2;
      beats[i]    = (len_full[i] + LW'(DPB - 1)) / LW'(DPB);
      elig[i]     = src_hdr_valid_i[i] & hdr_cred_ok_i[i] &
                    (~src_has_data_i[i] | (data_cred_i[i*CRED_W +: CRED_W] >= CRED_W'(need[i])));
    end
  end

  // Walk downward so the lowest offset from rr is the last (winning) assignment.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    any_elig = 1'b0;
    pick     = rr_q;
    for (int k = 2; k >= 0; k--) begin
      idx = (32'(rr_q) + 32'(k)) % 3;
      if (elig[idx]) begin
        any_elig = 1'b1;
        pick     = 2'(idx);
      end
    end
  end

  assign g_next = (g_q == 2'd2) ? 2'd0 : g_q + 2'd1;

  always_comb begin
    state_d            = state_q;
    g_d                = g_q;
    rr_d               = rr_q;
    cnt_d              = cnt_q;
    src_hdr_ready_o    = '0;
    src_data_ready_o   = '0;
    hdr_consume_o      = '0;
    data_consume_v_o   = '0;
    data_consume_o     = '0;
    tx.tx_hdr_o        = '0;
    tx.tx_hdr_valid_o  = 1'b0;
    tx.tx_data_o       = '0;
    tx.tx_data_valid_o = 1'b0;
    tx.tx_data_last_o  = 1'b0;
    tx.tx_src_o        = '0;

    unique case (state_q)
      StIdle: begin
        // No grant (and no credit pulse) may leak out while reset is held.
        if (any_elig && rst_n) begin
          g_d                 = pick;
          state_d             = StHdr;
          hdr_consume_o[pick] = 1'b1;
          if (src_has_data_i[pick]) begin
            data_consume_v_o[pick] = 1'b1;
            data_consume_o         = CRED_W'(need[pick]);
          end
        end
      end
      StHdr: begin
        tx.tx_hdr_o          = src_hdr_i[32'(g_q)*HDR_W +: HDR_W];
        tx.tx_hdr_valid_o    = 1'b1;
        tx.tx_src_o          = g_q;
        src_hdr_ready_o[g_q] = tx.tx_hdr_ready_i;
        if (tx.tx_hdr_ready_i) begin
          if (src_has_data_i[g_q]) begin
            cnt_d   = beats[g_q];
            state_d = StData;
          end else begin
            rr_d    = g_next;
            state_d = StIdle;
          end
        end
      end
      StData: begin
        tx.tx_data_o          = src_data_i[32'(g_q)*DATA_W +: DATA_W];
        tx.tx_data_valid_o    = src_data_valid_i[g_q];
        tx.tx_data_last_o     = src_data_valid_i[g_q] & (cnt_q == LW'(1));
        tx.tx_src_o           = g_q;
        src_data_ready_o[g_q] = tx.tx_data_ready_i;
        if (src_data_valid_i[g_q] && tx.tx_data_ready_i) begin
          cnt_d = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            rr_d    = g_next;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      g_q     <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tl_tx_arb.sv
// Bench for tl_tx_arb: transaction-level reference model checked every cycle, source models
// that feed numbered payload beats, and directed scenarios with hand-computed expectations.
module tb_tl_tx_arb;
  localparam int unsigned HDR_W  = 128;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned LEN_W  = 10;
  localparam int unsigned CRED_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3*HDR_W-1:0]  src_hdr;
  logic [2:0]          hv, hrdy, hd, dv, drdy, hok, hcons, dcons_v;
  logic [3*LEN_W-1:0]  slen;
  logic [3*DATA_W-1:0] sdata;
  logic [3*CRED_W-1:0] dcred;
  logic [CRED_W-1:0]   dcons;

  tl_tx_arb_if #(.HDR_W(HDR_W), .DATA_W(DATA_W)) tx_if ();

  tl_tx_arb #(.HDR_W(HDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .CRED_W(CRED_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .src_hdr_i        (src_hdr),
    .src_hdr_valid_i  (hv),
    .src_hdr_ready_o  (hrdy),
    .src_has_data_i   (hd),
    .src_len_i        (slen),
    .src_data_i       (sdata),
    .src_data_valid_i (dv),
    .src_data_ready_o (drdy),
    .hdr_cred_ok_i    (hok),
    .data_cred_i      (dcred),
    .hdr_consume_o    (hcons),
    .data_consume_v_o (dcons_v),
    .data_consume_o   (dcons),
    .tx               (tx_if.master)
  );

  int checks = 0;
  int errors = 0;
  int pend [3];
  int bcnt [3];

  // Reference model: phase 0 arbitrate, 1 header, 2 payload.
  int m_phase, m_g, m_rr, m_left, m_total;
  // Observations of the DUT for the directed literal checks.
  int glog [$];
  int gcyc [$];
  int cyc, beats_seen, last_cnt, last_idx, hdr_tx, cons_amt;
  logic [2:0] cons_hdr, cons_dv;
  logic [3*HDR_W-1:0] p_hdr;
  logic [2:0] p_hv, p_acc;

  always_comb for (int i = 0; i < 3; i++) hv[i] = (pend[i] != 0);

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  function automatic logic [DATA_W-1:0] pat(input int i, input int k);
    return {(DATA_W/32){32'(i*1000 + k + 1)}};
  endfunction

  function automatic int len_of(input int i);
    int l;
    l = int'(slen[i*LEN_W +: LEN_W]);
    return (l == 0) ? 1024 : l;
  endfunction

  function automatic int need_of(input int i);
    return (len_of(i) + 3) / 4;
  endfunction

  function automatic int beats_of(input int i);
    return (len_of(i) + (DATA_W/32) - 1) / (DATA_W/32);
  endfunction

  function automatic bit elig_of(input int i);
    return hv[i] && hok[i] && (!hd[i] || int'(dcred[i*CRED_W +: CRED_W]) >= need_of(i));
  endfunction

  function automatic int gl(input int k);
    return (k < glog.size()) ? glog[k] : -1;
  endfunction

  always @(negedge clk) begin
    logic [63:0]     ac, ec;
    logic [2:0]      e_hr, e_dr, e_hc, e_dv;
    logic [CRED_W-1:0] e_da;
    logic            e_hv, e_vv, e_last;
    logic [1:0]      e_src;
    int              g;
    cyc++;
    ac = 64'({hrdy, drdy, hcons, dcons_v, dcons, tx_if.tx_hdr_valid_o, tx_if.tx_data_valid_o,
              tx_if.tx_data_last_o, tx_if.tx_src_o});
    if (!rst_n) begin
      chk("reset_ctrl", ac, 0);
      chk("reset_bus", {tx_if.tx_hdr_o, tx_if.tx_data_o}, 0);
      m_phase = 0;
      m_rr    = 0;
      for (int i = 0; i < 3; i++) begin
        bcnt[i] = 0;
        sdata[i*DATA_W +: DATA_W] = pat(i, 0);
      end
    end else begin
      for (int i = 0; i < 3; i++)
        if (p_hv[i] && !p_acc[i] &&
            (!hv[i] || src_hdr[i*HDR_W +: HDR_W] != p_hdr[i*HDR_W +: HDR_W]))
          $error("source %0d broke the hold-until-accepted rule", i);
      {e_hr, e_dr, e_hc, e_dv, e_da, e_hv, e_vv, e_last, e_src} = '0;
      case (m_phase)
        0: begin
          g = -1;
          for (int k = 0; k < 3; k++)
            if (g < 0 && elig_of((m_rr + k) % 3)) g = (m_rr + k) % 3;
          if (g >= 0) begin
            e_hc[g] = 1'b1;
            if (hd[g]) begin
              e_dv[g] = 1'b1;
              e_da    = CRED_W'(need_of(g));
            end
            m_g     = g;
            m_phase = 1;
          end
        end
        1: begin
          e_hv          = 1'b1;
          e_src         = 2'(m_g);
          e_hr[m_g]     = tx_if.tx_hdr_ready_i;
          chk("tx_hdr", tx_if.tx_hdr_o, src_hdr[m_g*HDR_W +: HDR_W]);
          if (tx_if.tx_hdr_ready_i) begin
            hdr_tx++;
            if (hd[m_g]) begin
              m_left  = beats_of(m_g);
              m_total = m_left;
              m_phase = 2;
            end else begin
              m_rr    = (m_g + 1) % 3;
              m_phase = 0;
            end
          end
        end
        default: begin
          e_vv      = dv[m_g];
          e_src     = 2'(m_g);
          e_dr[m_g] = tx_if.tx_data_ready_i;
          e_last    = dv[m_g] && (m_left == 1);
          chk("tx_data", tx_if.tx_data_o, pat(m_g, m_total - m_left));
          if (dv[m_g] && tx_if.tx_data_ready_i) begin
            m_left--;
            if (m_left == 0) begin
              m_rr    = (m_g + 1) % 3;
              m_phase = 0;
            end
          end
        end
      endcase
      ec = 64'({e_hr, e_dr, e_hc, e_dv, e_da, e_hv, e_vv, e_last, e_src});
      chk("ctrl", ac, ec);

      if (hcons != 0) begin
        glog.push_back(hcons[0] ? 0 : hcons[1] ? 1 : 2);
        gcyc.push_back(cyc);
        cons_hdr = hcons;
        cons_dv  = dcons_v;
        cons_amt = int'(dcons);
      end
      if (tx_if.tx_data_valid_o && tx_if.tx_data_ready_i) begin
        beats_seen++;
        if (tx_if.tx_data_last_o) begin
          last_cnt++;
          last_idx = beats_seen;
        end
      end

      p_acc = hrdy & hv;
      for (int i = 0; i < 3; i++) begin
        if (hrdy[i] && hv[i]) begin
          pend[i] = pend[i] - 1;
          bcnt[i] = 0;
          sdata[i*DATA_W +: DATA_W] = pat(i, 0);
        end
        if (drdy[i] && dv[i]) begin
          bcnt[i]++;
          sdata[i*DATA_W +: DATA_W] = pat(i, bcnt[i]);
        end
      end
    end
    p_hv  = hv;
    p_hdr = src_hdr;
    if (!rst_n) p_acc = '0;
  end

  task automatic clear_logs();
    glog.delete();
    gcyc.delete();
    beats_seen = 0;
    last_cnt   = 0;
    last_idx   = 0;
    hdr_tx     = 0;
    cons_amt   = 0;
    cons_hdr   = '0;
    cons_dv    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) pend[i] = 0;
    hok   = '0;
    hd    = '0;
    dcred = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic set_src(input int i, input int has_data, input int len, input int cred,
                         input int n);
    src_hdr[i*HDR_W +: HDR_W]   = {32'hC0DE_0000 + 32'(i), 32'(len), 32'(cred), 32'(n)};
    hd[i]                       = has_data[0];
    slen[i*LEN_W +: LEN_W]      = LEN_W'(len);
    dcred[i*CRED_W +: CRED_W]   = CRED_W'(cred);
    hok[i]                      = 1'b1;
    pend[i]                     = n;
  endtask

  task automatic wait_src(input int i, input int budget, input string nm);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      done = (pend[i] == 0) && (m_phase == 0);
    end
    if (!done) timeout(nm);
    #1;
  endtask

  task automatic wait_all(input int budget, input string nm);
    for (int i = 0; i < 3; i++) wait_src(i, budget, nm);
  endtask

  task automatic wait_beats(input int n, input int budget, input string nm);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      done = (beats_seen >= n);
    end
    if (!done) timeout(nm);
  endtask

  initial begin
    src_hdr = '0;
    slen    = '0;
    dv      = 3'b111;
    tx_if.tx_hdr_ready_i  = 1'b1;
    tx_if.tx_data_ready_i = 1'b1;
    cyc = 0;
    p_hv = '0;
    p_acc = '0;
    p_hdr = '0;
    m_phase = 0; m_rr = 0; m_g = 0; m_left = 0; m_total = 0;
    for (int i = 0; i < 3; i++) begin
      bcnt[i] = 0;
      sdata[i*DATA_W +: DATA_W] = pat(i, 0);
    end

    // T1: header-only completion; pointer must advance past src2 back to 0.
    do_reset();
    set_src(2, 0, 0, 0, 1);
    wait_all(20, "T1_wait");
    chk("T1_hdr_consume", 64'(cons_hdr), 64'(3'b100));
    chk("T1_data_consume_v", 64'(cons_dv), 0);
    chk("T1_hdr_count", 64'(hdr_tx), 1);
    clear_logs();
    set_src(1, 0, 0, 0, 1);
    set_src(2, 0, 0, 0, 1);
    wait_all(20, "T1_rr_wait");
    chk("T1_rr_next", 64'(gl(0)), 1);

    // T2: 16 DW -> 4 credits, 2 beats; framer stalls 3 cycles after beat 1.
    do_reset();
    set_src(0, 1, 16, 4, 1);
    wait_beats(1, 30, "T2_beat1");
    #1 tx_if.tx_data_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 tx_if.tx_data_ready_i = 1'b1;
    wait_all(30, "T2_wait");
    chk("T2_consume", 64'(cons_amt), 4);
    chk("T2_beats", 64'(beats_seen), 2);
    chk("T2_last_count", 64'(last_cnt), 1);
    chk("T2_last_idx", 64'(last_idx), 2);

    // T3: all three contending -> 0,1,2,0 with one arbitration cycle between TLPs.
    do_reset();
    set_src(0, 0, 0, 0, 2);
    set_src(1, 0, 0, 0, 1);
    set_src(2, 0, 0, 0, 1);
    wait_all(40, "T3_wait");
    chk("T3_grants", 64'(glog.size()), 4);
    chk("T3_order", {32'(gl(0)), 32'(gl(1)), 32'(gl(2)), 32'(gl(3))}, {32'd0, 32'd1, 32'd2, 32'd0});
    for (int k = 0; k + 1 < gcyc.size(); k++) chk("T3_gap", 64'(gcyc[k+1] - gcyc[k]), 2);

    // T4: src1 short of data credit is skipped; granted once credit arrives.
    do_reset();
    set_src(1, 1, 8, 1, 1);
    set_src(2, 0, 0, 0, 1);
    wait_src(2, 20, "T4_src2");
    repeat (3) @(posedge clk);
    chk("T4_starved", 64'(glog.size()), 1);
    #1 dcred[1*CRED_W +: CRED_W] = CRED_W'(2);
    wait_all(30, "T4_wait");
    chk("T4_order", {32'(gl(0)), 32'(gl(1))}, {32'd2, 32'd1});
    chk("T4_consume", 64'(cons_amt), 2);

    // T5: length 0 is 1024 DW -> 256 credits, 128 beats.
    do_reset();
    set_src(0, 1, 0, 300, 1);
    wait_all(400, "T5_wait");
    chk("T5_consume", 64'(cons_amt), 256);
    chk("T5_beats", 64'(beats_seen), 128);
    chk("T5_last_count", 64'(last_cnt), 1);
    chk("T5_last_idx", 64'(last_idx), 128);

    // T6: async reset while beat 3 is on the bus.
    do_reset();
    set_src(0, 1, 64, 16, 1);
    wait_beats(2, 30, "T6_beat2");
    #1 rst_n = 1'b0;
    #1;
    chk("T6_rst_ctrl", 64'({hrdy, drdy, hcons, dcons_v, dcons, tx_if.tx_hdr_valid_o,
                            tx_if.tx_data_valid_o, tx_if.tx_data_last_o, tx_if.tx_src_o}), 0);
    chk("T6_rst_data", tx_if.tx_data_o, 0);
    pend[0] = 0;
    hok = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("T6_beats_abandoned", 64'(beats_seen), 2);
    clear_logs();
    set_src(0, 0, 0, 0, 1);
    set_src(1, 0, 0, 0, 1);
    wait_all(30, "T6_wait");
    chk("T6_rr_after", {32'(gl(0)), 32'(gl(1))}, {32'd0, 32'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
